// File: rtl/axi_sram_slave.sv
// AXI responder backed by an on-chip word array.
// Independent read and write FSMs, one burst outstanding on each side.
module axi_sram_slave #(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    logic [31:0] mem [0:DEPTH-1];

    r_state_t    r_state, r_next;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [7:0]  r_cnt;

    w_state_t    w_state, w_next;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [8:0]  w_cnt;
    logic        w_err;

    // Next beat address for FIXED / INCR / WRAP; WRAP with an illegal length acts as INCR.
    function automatic logic [31:0] next_addr(
        input logic [31:0] a,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] res;
        logic        wrap_ok;
        step    = 32'd1 << size;
        mask    = (({24'd0, len} + 32'd1) << size) - 32'd1;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        res     = a + step;
        if (burst == 2'b00) begin
            res = a;
        end else if (burst == 2'b10 && wrap_ok) begin
            res = (a & ~mask) | ((a + step) & mask);
        end
        return res;
    endfunction

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_cnt == r_len);
                if (rready && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read burst context: capture on AR, advance on each non-final R beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            rid     <= '0;
        end else if (arvalid && arready) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= '0;
            rid     <= arid;
        end else if (rvalid && rready && !rlast) begin
            r_addr  <= next_addr(r_addr, r_len, r_size, r_burst);
            r_cnt   <= r_cnt + 8'd1;
        end
    end

    assign rdata = mem[r_addr[ADDR_W-1:2]];
    assign rresp = 2'b00;

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Write FSM next state and handshake outputs.
    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        unique case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = w_err ? 2'b10 : 2'b00;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst context: capture on AW, advance per W beat, flag length mismatch at wlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bid     <= '0;
        end else if (awvalid && awready) begin
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bid     <= awid;
        end else if (wvalid && wready) begin
            w_addr  <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt   <= w_cnt + 9'd1;
            if (wlast) w_err <= (w_cnt != {1'b0, w_len});
        end
    end

    // Byte-masked array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wvalid && wready) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr[ADDR_W-1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule
